// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin stream arbiter with registered output stage
// Optional packet locking is enabled by defining STREAM_ARB_PKT_LOCK_EN; when it is
// undefined every beat is arbitrated on its own and req_last is only forwarded.
module stream_rr_arbiter #(
    parameter  int DW   = 32,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic                 down_valid,
    output logic [DW-1:0]        down_data,
    output logic                 down_last,
    output logic [IDW-1:0]       down_id,
    input  logic                 down_ready
);

    logic            stage_ready;
    logic            xfer;
    logic            grant_valid;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  ptr;
    logic [DW-1:0]   req_word [NREQ];
    logic [DW-1:0]   sel_data;
    logic            sel_last;

    // The output register can accept a new beat when it is empty or being drained.
    assign stage_ready = !down_valid || down_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_word[gi]  = req_data[gi*DW +: DW];
            // Ready is held low while reset is asserted so nothing is consumed upstream.
            assign req_ready[gi] = rst_n && stage_ready && grant_valid && (grant == IDW'(gi));
        end
    endgenerate

    assign sel_data = req_word[grant];
    assign sel_last = req_last[grant];
    assign xfer     = |(req_valid & req_ready);

`ifdef STREAM_ARB_PKT_LOCK_EN
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  lock_id;

    // State register: reset always discards any packet in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: lock on the first beat of a multi-beat packet, unlock on its last beat.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (xfer && !sel_last) state_nxt = ST_LOCKED;
            ST_LOCKED: if (xfer && sel_last)  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Round-robin pointer moves only when a packet completes; lock_id records the packet owner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= IDW'(NREQ - 1);
            lock_id <= '0;
        end else if (xfer) begin
            if (state == ST_IDLE && !sel_last) begin
                lock_id <= grant;
            end
            if (sel_last) begin
                ptr <= grant;
            end
        end
    end
`else
    // Round-robin pointer follows every transferred beat since beats are arbitrated independently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= IDW'(NREQ - 1);
        end else if (xfer) begin
            ptr <= grant;
        end
    end
`endif

    // Grant: first valid requester after ptr with wrap-around; a held lock overrides the search.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
        // Walk from the farthest candidate back to the nearest so the nearest valid one wins.
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (req_valid[cand]) begin
                grant_valid = 1'b1;
                grant       = cand;
            end
        end
`ifdef STREAM_ARB_PKT_LOCK_EN
        if (state == ST_LOCKED) begin
            grant_valid = 1'b1;
            grant       = lock_id;
        end
`endif
    end

    // Output valid: refill or empty the stage whenever it can advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            down_valid <= 1'b0;
        end else if (stage_ready) begin
            down_valid <= xfer;
        end
    end

    // Output payload, last flag and source id load on an upstream transfer; they carry no reset.
    always_ff @(posedge clk) begin
        if (stage_ready && xfer) begin
            down_data <= sel_data;
            down_last <= sel_last;
            down_id   <= grant;
        end
    end

endmodule
